// File: rtl/lstm_param_loader.sv
// lstm_param_loader
//   Receives the host-to-LSTM parameter byte stream and stores the weight,
//   bias and initial-context segments. Weight and bias are read back through
//   registered synchronous ports. Context is exposed as flat registers.
//   param_ready is high once all three segments have been loaded with exactly
//   their nominal length.
//
//   Optional build macro: LSTM_PARAM_CHECKSUM_EN
//     defined   : param_csum is the 16-bit wraparound sum of the accepted bytes
//                 of the current or most recent segment
//     undefined : param_csum is tied to zero
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   lstm_init             byte-valid qualifier
//   param_type            0 weight, 1 bias, 2 context, 3..7 ignored
//   lstm_param            parameter byte
//   w_rd_addr/w_rd_data   weight read port, 1-cycle latency
//   b_rd_addr/b_rd_data   bias read port, 1-cycle latency
//   ctx_h, ctx_c          initial H / C, first byte in the MSBs
//   w_loaded, b_loaded,
//   ctx_loaded            per-segment complete flags
//   param_ready           all three segments loaded
//   param_err             sticky error (underrun, overrun)
//   param_csum            segment checksum (see macro above)
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no segment open
// LOAD_W   | receiving weight bytes
// LOAD_B   | receiving bias bytes
// LOAD_CTX | receiving context bytes (H first, then C)

module lstm_param_loader #(
   parameter  int W_BYTES   = 512,
   parameter  int B_BYTES   = 32,
   parameter  int CTX_BYTES = 16,
   localparam int W_AW      = $clog2(W_BYTES),
   localparam int B_AW      = $clog2(B_BYTES)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     lstm_init,
   input  logic [2:0]               param_type,
   input  logic [7:0]               lstm_param,
   input  logic [W_AW-1:0]          w_rd_addr,
   output logic [7:0]               w_rd_data,
   input  logic [B_AW-1:0]          b_rd_addr,
   output logic [7:0]               b_rd_data,
   output logic [CTX_BYTES*4-1:0]   ctx_h,
   output logic [CTX_BYTES*4-1:0]   ctx_c,
   output logic                     w_loaded,
   output logic                     b_loaded,
   output logic                     ctx_loaded,
   output logic                     param_ready,
   output logic                     param_err,
   output logic [15:0]              param_csum
);

   // Counter must be able to hold the full segment length of the largest segment.
   localparam int CW       = $clog2(W_BYTES + 1);
   localparam int CTX_BITS = CTX_BYTES * 8;

   typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, LOAD_CTX} state_t;

   state_t              state, state_nxt, req_state;
   logic [CW-1:0]       cnt, cnt_nxt, seg_size, wr_addr;
   logic                overrun, overrun_nxt;
   logic                err_nxt, w_nxt, b_nxt, ctx_nxt;
   logic                req_load, seg_entry, seg_cont, seg_end, cnt_full;
   logic                accept, drop, end_ok;
   logic                w_we, b_we, ctx_we;
   logic [CTX_BITS-1:0] ctx_q;

   logic [7:0] w_mem [W_BYTES];
   logic [7:0] b_mem [B_BYTES];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         overrun    <= 1'b0;
         param_err  <= 1'b0;
         w_loaded   <= 1'b0;
         b_loaded   <= 1'b0;
         ctx_loaded <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         overrun    <= overrun_nxt;
         param_err  <= err_nxt;
         w_loaded   <= w_nxt;
         b_loaded   <= b_nxt;
         ctx_loaded <= ctx_nxt;
      end
   end

   always_comb begin
      req_load    = 1'b0;
      req_state   = IDLE;
      seg_size    = '0;
      state_nxt   = IDLE;
      cnt_nxt     = cnt;
      overrun_nxt = overrun;
      err_nxt     = param_err;
      w_nxt       = w_loaded;
      b_nxt       = b_loaded;
      ctx_nxt     = ctx_loaded;

      if (lstm_init) begin
         unique case (param_type)
            3'd0:    begin req_load = 1'b1; req_state = LOAD_W;   end
            3'd1:    begin req_load = 1'b1; req_state = LOAD_B;   end
            3'd2:    begin req_load = 1'b1; req_state = LOAD_CTX; end
            default: begin req_load = 1'b0; req_state = IDLE;     end
         endcase
      end

      unique case (state)
         LOAD_W:   seg_size = CW'(W_BYTES);
         LOAD_B:   seg_size = CW'(B_BYTES);
         LOAD_CTX: seg_size = CW'(CTX_BYTES);
         default:  seg_size = '0;
      endcase

      // A type change while lstm_init stays high both closes the open segment
      // and opens the new one on the same edge.
      seg_cont  = req_load && (state == req_state);
      seg_entry = req_load && (state != req_state);
      seg_end   = (state != IDLE) && !seg_cont;
      cnt_full  = (cnt == seg_size);
      drop      = seg_cont && cnt_full;
      accept    = seg_entry || (seg_cont && !cnt_full);
      end_ok    = seg_end && cnt_full && !overrun;
      wr_addr   = seg_entry ? '0 : cnt;

      w_we   = accept && (req_state == LOAD_W)   && !rst;
      b_we   = accept && (req_state == LOAD_B)   && !rst;
      ctx_we = accept && (req_state == LOAD_CTX) && !rst;

      state_nxt = req_load ? req_state : IDLE;

      if (seg_entry) begin
         cnt_nxt     = CW'(1);
         overrun_nxt = 1'b0;
      end else if (accept) begin
         cnt_nxt = cnt + CW'(1);
      end else if (drop) begin
         overrun_nxt = 1'b1;
      end

      if (drop || (seg_end && !end_ok))
         err_nxt = 1'b1;

      if (end_ok) begin
         if (state == LOAD_W)   w_nxt   = 1'b1;
         if (state == LOAD_B)   b_nxt   = 1'b1;
         if (state == LOAD_CTX) ctx_nxt = 1'b1;
      end
      if (seg_entry) begin
         if (req_state == LOAD_W)   w_nxt   = 1'b0;
         if (req_state == LOAD_B)   b_nxt   = 1'b0;
         if (req_state == LOAD_CTX) ctx_nxt = 1'b0;
      end
   end

   assign param_ready = w_loaded & b_loaded & ctx_loaded;

   // RAM arrays carry no reset; reads are read-before-write.
   always_ff @(posedge clk) begin
      if (w_we) w_mem[wr_addr[W_AW-1:0]] <= lstm_param;
      if (b_we) b_mem[wr_addr[B_AW-1:0]] <= lstm_param;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_rd_data <= 8'h00;
         b_rd_data <= 8'h00;
      end else begin
         w_rd_data <= w_mem[w_rd_addr];
         b_rd_data <= b_mem[b_rd_addr];
      end
   end

   // Context byte k lands MSB-first; H occupies the upper half of ctx_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctx_q <= '0;
      end else if (ctx_we) begin
         for (int k = 0; k < CTX_BYTES; k++)
            if (wr_addr == CW'(k))
               ctx_q[CTX_BITS-1-8*k -: 8] <= lstm_param;
      end
   end

   assign ctx_h = ctx_q[CTX_BITS-1 -: CTX_BYTES*4];
   assign ctx_c = ctx_q[CTX_BYTES*4-1:0];

`ifdef LSTM_PARAM_CHECKSUM_EN
   logic [15:0] csum_q;

   always_ff @(posedge clk) begin
      if (rst)
         csum_q <= 16'h0000;
      else if (seg_entry)
         csum_q <= {8'h00, lstm_param};
      else if (accept)
         csum_q <= csum_q + {8'h00, lstm_param};
   end

   assign param_csum = csum_q;
`else
   assign param_csum = 16'h0000;
`endif

endmodule

// File: tb/tb_lstm_param_loader.sv
module tb_lstm_param_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        lstm_init;
   logic [2:0]  param_type;
   logic [7:0]  lstm_param;
   logic [8:0]  w_rd_addr;
   logic [7:0]  w_rd_data;
   logic [4:0]  b_rd_addr;
   logic [7:0]  b_rd_data;
   logic [63:0] ctx_h;
   logic [63:0] ctx_c;
   logic        w_loaded, b_loaded, ctx_loaded, param_ready, param_err;
   logic [15:0] param_csum;

   lstm_param_loader dut (
      .clk         (clk),
      .rst         (rst),
      .lstm_init   (lstm_init),
      .param_type  (param_type),
      .lstm_param  (lstm_param),
      .w_rd_addr   (w_rd_addr),
      .w_rd_data   (w_rd_data),
      .b_rd_addr   (b_rd_addr),
      .b_rd_data   (b_rd_data),
      .ctx_h       (ctx_h),
      .ctx_c       (ctx_c),
      .w_loaded    (w_loaded),
      .b_loaded    (b_loaded),
      .ctx_loaded  (ctx_loaded),
      .param_ready (param_ready),
      .param_err   (param_err),
      .param_csum  (param_csum)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: what the host has delivered, in plain arrays.
   logic [7:0]  w_ref   [512];
   logic [7:0]  b_ref   [32];
   logic [7:0]  ctx_ref [16];
   bit          flag_ref [3];
   bit          err_ref;
   logic [15:0] csum_ref;
   logic [7:0]  sb [600];

   function automatic int seg_size(input int t);
      if (t == 0) return 512;
      if (t == 1) return 32;
      return 16;
   endfunction

   function automatic logic [63:0] ctx_pack(input int base);
      logic [63:0] r = '0;
      for (int k = 0; k < 8; k++) r = {r[55:0], ctx_ref[base+k]};
      return r;
   endfunction

   function automatic logic [4:0] flags_exp();
      return {flag_ref[0], flag_ref[1], flag_ref[2],
              flag_ref[0] & flag_ref[1] & flag_ref[2], err_ref};
   endfunction

   function automatic logic [15:0] csum_exp();
`ifdef LSTM_PARAM_CHECKSUM_EN
      return csum_ref;
`else
      return 16'h0000;
`endif
   endfunction

   // A segment of n bytes sb[0..n-1] was delivered for type t.
   task automatic model_seg(input int t, input int n);
      int acc = (n < seg_size(t)) ? n : seg_size(t);
      int sum = 0;
      for (int i = 0; i < acc; i++) begin
         if (t == 0) w_ref[i] = sb[i];
         else if (t == 1) b_ref[i] = sb[i];
         else ctx_ref[i] = sb[i];
         sum += sb[i];
      end
      csum_ref = 16'(sum);
      flag_ref[t] = (n == seg_size(t));
      if (n != seg_size(t)) err_ref = 1'b1;
   endtask

   task automatic drive_seg(input int t, input int lo, input int hi, input bit fall);
      for (int i = lo; i < hi; i++) begin
         lstm_init = 1'b1; param_type = 3'(t); lstm_param = sb[i];
         @(posedge clk); #1;
      end
      if (fall) begin
         lstm_init = 1'b0; param_type = 3'd7; lstm_param = 8'h00;
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; lstm_init = 1'b0; param_type = 3'd7;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int t = 0; t < 3; t++) flag_ref[t] = 1'b0;
      for (int i = 0; i < 16; i++) ctx_ref[i] = 8'h00;
      err_ref = 1'b0; csum_ref = 16'h0000;
   endtask

   task automatic read_w(input int a, output logic [7:0] d);
      w_rd_addr = 9'(a); @(posedge clk); #1; d = w_rd_data;
   endtask

   task automatic read_b(input int a, output logic [7:0] d);
      b_rd_addr = 5'(a); @(posedge clk); #1; d = b_rd_data;
   endtask

   function automatic logic [4:0] flags_dut();
      return {w_loaded, b_loaded, ctx_loaded, param_ready, param_err};
   endfunction

   task automatic test_reset();
      rst = 1'b1; lstm_init = 1'b0; param_type = 3'd7; lstm_param = 8'h00;
      w_rd_addr = '0; b_rd_addr = '0;
      do_reset();
      rst = 1'b1; #1;
      n_cmp++; if (flags_dut() !== 5'b0) begin n_bad++;
         $display("FAIL reset_flags: got %b expected %b", flags_dut(), 5'b0); end
      n_cmp++; if ({ctx_h, ctx_c} !== 128'h0) begin n_bad++;
         $display("FAIL reset_ctx: got %h expected 0", {ctx_h, ctx_c}); end
      n_cmp++; if ({w_rd_data, b_rd_data, param_csum} !== 32'h0) begin n_bad++;
         $display("FAIL reset_rd_csum: got %h expected 0", {w_rd_data, b_rd_data, param_csum}); end
      @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_weight_load();
      logic [7:0] d;
      int a;
      for (int i = 0; i < 512; i++) sb[i] = 8'(i);
      drive_seg(0, 0, 512, 1); model_seg(0, 512);
      n_cmp++; if (flags_dut() !== flags_exp()) begin n_bad++;
         $display("FAIL w_load_flags: got %b expected %b", flags_dut(), flags_exp()); end
      read_w(9'h1FF, d);
      n_cmp++; if (d !== 8'hFF) begin n_bad++;
         $display("FAIL w_rd_1ff: got %h expected ff", d); end
      for (int k = 0; k < 6; k++) begin
         a = $urandom_range(0, 511);
         read_w(a, d);
         n_cmp++; if (d !== w_ref[a]) begin n_bad++;
            $display("FAIL w_rd_rand[%0d]: got %h expected %h", a, d, w_ref[a]); end
      end
   endtask

   task automatic test_full_sequence();
      logic [7:0] d;
      for (int i = 0; i < 32; i++) sb[i] = 8'hA0 + 8'(i);
      drive_seg(1, 0, 32, 1); model_seg(1, 32);
      for (int i = 0; i < 16; i++) sb[i] = 8'(i + 1);
      drive_seg(2, 0, 16, 1); model_seg(2, 16);
      n_cmp++; if (flags_dut() !== 5'b11110) begin n_bad++;
         $display("FAIL full_flags: got %b expected %b", flags_dut(), 5'b11110); end
      n_cmp++; if (ctx_h !== 64'h0102030405060708) begin n_bad++;
         $display("FAIL full_ctx_h: got %h expected 0102030405060708", ctx_h); end
      n_cmp++; if (ctx_c !== 64'h090A0B0C0D0E0F10) begin n_bad++;
         $display("FAIL full_ctx_c: got %h expected 090a0b0c0d0e0f10", ctx_c); end
      read_b(5, d);
      n_cmp++; if (d !== 8'hA5) begin n_bad++;
         $display("FAIL full_b_rd5: got %h expected a5", d); end
      n_cmp++; if (param_csum !== csum_exp()) begin n_bad++;
         $display("FAIL full_csum: got %h expected %h", param_csum, csum_exp()); end
   endtask

   task automatic test_reload();
      logic [7:0] d;
      int a;
      for (int i = 0; i < 32; i++) sb[i] = 8'($urandom);
      drive_seg(1, 0, 1, 0);
      n_cmp++; if (flags_dut() !== 5'b10100) begin n_bad++;
         $display("FAIL reload_entry: got %b expected %b", flags_dut(), 5'b10100); end
      drive_seg(1, 1, 32, 1); model_seg(1, 32);
      n_cmp++; if (flags_dut() !== flags_exp()) begin n_bad++;
         $display("FAIL reload_done: got %b expected %b", flags_dut(), flags_exp()); end
      for (int k = 0; k < 4; k++) begin
         a = $urandom_range(0, 31);
         read_b(a, d);
         n_cmp++; if (d !== b_ref[a]) begin n_bad++;
            $display("FAIL reload_b_rd[%0d]: got %h expected %h", a, d, b_ref[a]); end
      end
   endtask

   task automatic test_type_switch();
      logic [7:0] first;
      for (int i = 0; i < 32; i++) sb[i] = 8'($urandom);
      drive_seg(1, 0, 32, 0); model_seg(1, 32);
      for (int i = 0; i < 16; i++) sb[i] = 8'($urandom);
      first = sb[0];
      drive_seg(2, 0, 16, 1); model_seg(2, 16);
      n_cmp++; if (flags_dut() !== flags_exp()) begin n_bad++;
         $display("FAIL switch_flags: got %b expected %b", flags_dut(), flags_exp()); end
      n_cmp++; if (ctx_h[63:56] !== first) begin n_bad++;
         $display("FAIL switch_first_byte: got %h expected %h", ctx_h[63:56], first); end
      n_cmp++; if ({ctx_h, ctx_c} !== {ctx_pack(0), ctx_pack(8)}) begin n_bad++;
         $display("FAIL switch_ctx: got %h expected %h", {ctx_h, ctx_c}, {ctx_pack(0), ctx_pack(8)}); end
      n_cmp++; if (param_csum !== csum_exp()) begin n_bad++;
         $display("FAIL switch_csum: got %h expected %h", param_csum, csum_exp()); end
   endtask

   task automatic test_ignored_types();
      for (int i = 0; i < 10; i++) begin
         lstm_init = 1'b1; param_type = 3'($urandom_range(3, 7)); lstm_param = 8'($urandom);
         @(posedge clk); #1;
      end
      lstm_init = 1'b0; param_type = 3'd7; @(posedge clk); #1;
      n_cmp++; if ({flags_dut(), param_csum} !== {flags_exp(), csum_exp()}) begin n_bad++;
         $display("FAIL ignored: got %h expected %h", {flags_dut(), param_csum}, {flags_exp(), csum_exp()}); end
      n_cmp++; if ({ctx_h, ctx_c} !== {ctx_pack(0), ctx_pack(8)}) begin n_bad++;
         $display("FAIL ignored_ctx: got %h expected %h", {ctx_h, ctx_c}, {ctx_pack(0), ctx_pack(8)}); end
   endtask

   task automatic test_checksum();
      logic [15:0] exp;
      for (int i = 0; i < 16; i++) sb[i] = 8'hFF;
      drive_seg(2, 0, 16, 1); model_seg(2, 16);
`ifdef LSTM_PARAM_CHECKSUM_EN
      exp = 16'h0FF0;
`else
      exp = 16'h0000;
`endif
      n_cmp++; if (param_csum !== exp) begin n_bad++;
         $display("FAIL csum_ff: got %h expected %h", param_csum, exp); end
      n_cmp++; if ({ctx_h, ctx_c} !== {128{1'b1}}) begin n_bad++;
         $display("FAIL csum_ctx: got %h expected all ones", {ctx_h, ctx_c}); end
   endtask

   task automatic test_underrun();
      for (int i = 0; i < 31; i++) sb[i] = 8'($urandom);
      drive_seg(1, 0, 31, 1); model_seg(1, 31);
      n_cmp++; if (flags_dut() !== flags_exp()) begin n_bad++;
         $display("FAIL underrun_flags: got %b expected %b", flags_dut(), flags_exp()); end
      n_cmp++; if (param_csum !== csum_exp()) begin n_bad++;
         $display("FAIL underrun_csum: got %h expected %h", param_csum, csum_exp()); end
   endtask

   task automatic test_overrun();
      logic [7:0] d;
      do_reset();
      for (int i = 0; i < 33; i++) sb[i] = 8'($urandom);
      sb[32] = ~sb[0];
      drive_seg(1, 0, 33, 1); model_seg(1, 33);
      n_cmp++; if (flags_dut() !== flags_exp()) begin n_bad++;
         $display("FAIL overrun_flags: got %b expected %b", flags_dut(), flags_exp()); end
      read_b(0, d);
      n_cmp++; if (d !== b_ref[0]) begin n_bad++;
         $display("FAIL overrun_b0: got %h expected %h", d, b_ref[0]); end
      n_cmp++; if (param_csum !== csum_exp()) begin n_bad++;
         $display("FAIL overrun_csum: got %h expected %h", param_csum, csum_exp()); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      int a;
      for (int i = 0; i < 100; i++) sb[i] = 8'($urandom);
      drive_seg(0, 0, 100, 0);
      for (int i = 0; i < 100; i++) w_ref[i] = sb[i];
      do_reset();
      n_cmp++; if (flags_dut() !== 5'b0) begin n_bad++;
         $display("FAIL mid_rst_flags: got %b expected %b", flags_dut(), 5'b0); end
      n_cmp++; if ({ctx_h, ctx_c} !== 128'h0) begin n_bad++;
         $display("FAIL mid_rst_ctx: got %h expected 0", {ctx_h, ctx_c}); end
      for (int i = 0; i < 512; i++) sb[i] = 8'($urandom);
      drive_seg(0, 0, 512, 1); model_seg(0, 512);
      n_cmp++; if (flags_dut() !== flags_exp()) begin n_bad++;
         $display("FAIL mid_reload_flags: got %b expected %b", flags_dut(), flags_exp()); end
      for (int k = 0; k < 6; k++) begin
         a = $urandom_range(0, 511);
         read_w(a, d);
         n_cmp++; if (d !== w_ref[a]) begin n_bad++;
            $display("FAIL mid_reload_w[%0d]: got %h expected %h", a, d, w_ref[a]); end
      end
   endtask

   initial begin
      test_reset();
      test_weight_load();
      test_full_sequence();
      test_reload();
      test_type_switch();
      test_ignored_types();
      test_checksum();
      test_underrun();
      test_overrun();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
